bcd_counter_div: RTL and testbench

Two-digit BCD counter with a built-in clock prescaler. It produces the `ones` and `tens` BCD digits that feed the board's BCD-to-7-segment decoders, one decoder per digit. Each digit is driven straight into a decoder's 4-bit `bcd` input. Counting is modulo `MOD_VAL` (e.g. seconds 00–59), up or down, at a rate of one step per `DIV_CNT` enabled clock cycles.

---
 rtl/bcd_counter_div.sv | 140 ++++++++++++++
 tb/tb_bcd_counter_div.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_div.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter_div
//  Description : Two-digit BCD up/down counter, modulo MOD_VAL, advanced once
//                every DIV_CNT enabled clock cycles by a built-in prescaler.
//                Provides synchronous clear and checked parallel load, plus
//                registered one-cycle tick and carry (wrap) pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter_div #(
    parameter int DIV_CNT = 100_000_000,
    parameter int MOD_VAL = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       tick,
    output logic       carry
);

    // Prescaler width is ceil(log2(DIV_CNT)); guard the degenerate case.
    localparam int              c_presc_w    = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(DIV_CNT - 1);

    // Highest displayable value split into its BCD digits.
    localparam logic [3:0]      c_max_tens   = 4'((MOD_VAL - 1) / 10);
    localparam logic [3:0]      c_max_ones   = 4'((MOD_VAL - 1) % 10);

    logic [c_presc_w-1:0] r_presc;
    logic [3:0]           r_ones;
    logic [3:0]           r_tens;
    logic                 r_tick;
    logic                 r_carry;

    logic                 w_step;
    logic                 w_load_ok;
    logic                 w_wrap;
    logic [3:0]           w_next_ones;
    logic [3:0]           w_next_tens;

    // A count step happens on the enabled cycle where the prescaler is at its last value.
    assign w_step = en && (r_presc == c_presc_last);

    // Load value must be valid BCD and below MOD_VAL, compared digit-wise.
    assign w_load_ok = (load_tens <= 4'd9) && (load_ones <= 4'd9) &&
                       ((load_tens < c_max_tens) ||
                        ((load_tens == c_max_tens) && (load_ones <= c_max_ones)));

    // Next digit values for a step in the current direction, per-digit BCD arithmetic.
    always_comb begin
        w_next_ones = r_ones;
        w_next_tens = r_tens;
        w_wrap      = 1'b0;
        if (up) begin
            if ((r_tens == c_max_tens) && (r_ones == c_max_ones)) begin
                w_next_ones = 4'd0;
                w_next_tens = 4'd0;
                w_wrap      = 1'b1;
            end else if (r_ones == 4'd9) begin
                w_next_ones = 4'd0;
                w_next_tens = r_tens + 4'd1;
            end else begin
                w_next_ones = r_ones + 4'd1;
            end
        end else begin
            if ((r_tens == 4'd0) && (r_ones == 4'd0)) begin
                w_next_ones = c_max_ones;
                w_next_tens = c_max_tens;
                w_wrap      = 1'b1;
            end else if (r_ones == 4'd0) begin
                w_next_ones = 4'd9;
                w_next_tens = r_tens - 4'd1;
            end else begin
                w_next_ones = r_ones - 4'd1;
            end
        end
    end

    // Prescaler: cleared by clr/load, otherwise advances and rolls over while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (clr || load) begin
            r_presc <= '0;
        end else if (en) begin
            if (w_step) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Digits: clr beats load beats step; a rejected load falls back to 00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ones <= 4'd0;
            r_tens <= 4'd0;
        end else if (clr) begin
            r_ones <= 4'd0;
            r_tens <= 4'd0;
        end else if (load) begin
            if (w_load_ok) begin
                r_ones <= load_ones;
                r_tens <= load_tens;
            end else begin
                r_ones <= 4'd0;
                r_tens <= 4'd0;
            end
        end else if (w_step) begin
            r_ones <= w_next_ones;
            r_tens <= w_next_tens;
        end
    end

    // Pulses: one cycle after a step that was not overridden by clr or load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            r_tick  <= w_step && !clr && !load;
            r_carry <= w_step && w_wrap && !clr && !load;
        end
    end

    assign ones  = r_ones;
    assign tens  = r_tens;
    assign tick  = r_tick;
    assign carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_counter_div
//  Description : Scoreboard bench for bcd_counter_div (DIV_CNT=4, MOD_VAL=60).
//                Directed scenarios followed by random stimulus, checked
//                against an integer-valued reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_div;

    localparam int DIV = 4;
    localparam int MOD = 60;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       tick;
    logic       carry;

    int         errors = 0;
    int         checks = 0;

    // Expected {tens, ones, tick, carry} after each rising edge.
    logic [9:0] exp_q[$];
    logic [9:0] mon_exp;

    // Reference model state: displayed value as a plain integer, prescaler count.
    int         m_v;
    int         m_p;

    bcd_counter_div #(
        .DIV_CNT (DIV),
        .MOD_VAL (MOD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up        (up),
        .clr       (clr),
        .load      (load),
        .load_tens (load_tens),
        .load_ones (load_ones),
        .ones      (ones),
        .tens      (tens),
        .tick      (tick),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got tens=%0d ones=%0d tick=%0b carry=%0b, expected tens=%0d ones=%0d tick=%0b carry=%0b",
                     name, $time, act[9:6], act[5:2], act[1], act[0],
                     exp[9:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [9:0] pack(input int v, input bit tk, input bit cy);
        return {4'(v / 10), 4'(v % 10), tk, cy};
    endfunction

    // Monitor: every edge the DUT presents a new output word; compare against the queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("scoreboard", {tens, ones, tick, carry}, mon_exp);
            end
        end
    end

    // Drive one cycle of inputs (called at a falling edge) and predict the result.
    task automatic cyc(input bit e, input bit u, input bit c, input bit l,
                       input logic [3:0] lt, input logic [3:0] lo);
        bit tk;
        bit cy;
        int lv;
        en = e; up = u; clr = c; load = l; load_tens = lt; load_ones = lo;
        tk = 1'b0;
        cy = 1'b0;
        if (!rst_n) begin
            m_v = 0;
            m_p = 0;
        end else if (c) begin
            m_v = 0;
            m_p = 0;
        end else if (l) begin
            lv  = int'(lt) * 10 + int'(lo);
            m_v = (lt <= 9 && lo <= 9 && lv < MOD) ? lv : 0;
            m_p = 0;
        end else if (e) begin
            if (m_p == DIV - 1) begin
                m_p = 0;
                tk  = 1'b1;
                if (u) begin
                    cy  = (m_v == MOD - 1);
                    m_v = (m_v + 1) % MOD;
                end else begin
                    cy  = (m_v == 0);
                    m_v = (m_v + MOD - 1) % MOD;
                end
            end else begin
                m_p = m_p + 1;
            end
        end
        exp_q.push_back(pack(m_v, tk, cy));
        @(negedge clk);
    endtask

    // Assert reset between edges and confirm outputs clear with no clock edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_immediate", {tens, ones, tick, carry}, 10'd0);
        m_v = 0;
        m_p = 0;
        exp_q.push_back(10'd0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0;
        load_tens = 4'd0; load_ones = 4'd0;
        m_v = 0;
        m_p = 0;
        @(negedge clk);
        cyc(0, 0, 0, 0, 4'd0, 4'd0);
        cyc(0, 0, 0, 0, 4'd0, 4'd0);
        rst_n = 1'b1;

        // Basic up count: ticks on cycles 4, 8, 12.
        repeat (12) cyc(1, 1, 0, 0, 4'd0, 4'd0);

        // Up wrap 59 -> 00.
        cyc(0, 1, 0, 1, 4'd5, 4'd9);
        repeat (6) cyc(1, 1, 0, 0, 4'd0, 4'd0);

        // Down borrow 10 -> 09, then down wrap 00 -> 59.
        cyc(0, 0, 0, 1, 4'd1, 4'd0);
        repeat (4) cyc(1, 0, 0, 0, 4'd0, 4'd0);
        cyc(0, 0, 0, 1, 4'd0, 4'd0);
        repeat (5) cyc(1, 0, 0, 0, 4'd0, 4'd0);

        // clr + load on the step edge, then load alone on the step edge.
        cyc(0, 1, 0, 1, 4'd2, 4'd3);
        repeat (3) cyc(1, 1, 0, 0, 4'd0, 4'd0);
        cyc(1, 1, 1, 1, 4'd4, 4'd4);
        cyc(1, 1, 0, 0, 4'd0, 4'd0);
        cyc(0, 1, 0, 1, 4'd2, 4'd3);
        repeat (3) cyc(1, 1, 0, 0, 4'd0, 4'd0);
        cyc(1, 1, 0, 1, 4'd4, 4'd4);
        repeat (5) cyc(1, 1, 0, 0, 4'd0, 4'd0);

        // Load boundaries: invalid digit, value == MOD, max legal, all-nines.
        cyc(0, 1, 0, 1, 4'd1, 4'hA);
        cyc(0, 1, 0, 1, 4'd6, 4'd0);
        cyc(0, 1, 0, 1, 4'd5, 4'd9);
        cyc(0, 1, 0, 1, 4'd9, 4'd9);
        cyc(0, 1, 0, 1, 4'hF, 4'd3);

        // Enable gating.
        cyc(0, 1, 1, 0, 4'd0, 4'd0);
        repeat (2) cyc(1, 1, 0, 0, 4'd0, 4'd0);
        repeat (10) cyc(0, 1, 0, 0, 4'd0, 4'd0);
        repeat (3) cyc(1, 1, 0, 0, 4'd0, 4'd0);

        // Async reset at 47 with prescaler 2, then restart.
        cyc(0, 1, 0, 1, 4'd4, 4'd7);
        repeat (2) cyc(1, 1, 0, 0, 4'd0, 4'd0);
        async_reset();
        cyc(1, 1, 0, 0, 4'd0, 4'd0);
        rst_n = 1'b1;
        repeat (5) cyc(1, 1, 0, 0, 4'd0, 4'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] lt;
            logic [3:0] lo;
            lt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
            lo = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 149) == 0) begin
                async_reset();
                rst_n = 1'b1;
            end
            cyc(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 39) == 0), ($urandom_range(0, 24) == 0), lt, lo);
        end

        // Let the final expectation drain, then confirm nothing is left over.
        en = 1'b0; clr = 1'b0; load = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
